// File: rtl/updown_counter_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_param_pkg
//  Description : Shared encodings for the parametrised up/down counter:
//                count direction and bound policy, so that parent designs
//                and benches drive mode/sat with the same values.
//  Revision    : 1.0 - initial release
// ============================================================================
package updown_counter_param_pkg;

    // Count direction (drives the mode input)
    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    // Bound policy (drives the sat input)
    localparam logic SAT_WRAP  = 1'b0;
    localparam logic SAT_HOLD  = 1'b1;

endpackage : updown_counter_param_pkg
`default_nettype wire

// File: rtl/updown_counter_param_next_val.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_param_next_val
//  Description : Combinational next-count, terminal-count and wrap detect
//                for the up/down counter. The caller decides whether the
//                next value is actually taken (enable/load/reset priority).
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param_next_val
    import updown_counter_param_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             mode,
    input  logic             sat,
    output logic [WIDTH-1:0] next_q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_max = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic w_at_max;
    logic w_at_zero;

    assign w_at_max  = (q == c_max);
    assign w_at_zero = (q == '0);

    // Terminal count is purely combinational so a cascaded stage sees it
    // in the same cycle and can step on the same edge as the wrap.
    assign tc = en & ((mode & w_at_max) | (~mode & w_at_zero));

    // Step one count in the selected direction, wrapping or holding at bounds
    always_comb begin
        next_q = q;
        wrap   = 1'b0;
        if (mode == MODE_UP) begin
            if (!w_at_max) begin
                next_q = q + c_one;
            end else if (sat == SAT_WRAP) begin
                next_q = '0;
                wrap   = 1'b1;
            end
        end else begin
            if (!w_at_zero) begin
                next_q = q - c_one;
            end else if (sat == SAT_WRAP) begin
                next_q = c_max;
                wrap   = 1'b1;
            end
        end
    end

endmodule : updown_counter_param_next_val
`default_nettype wire

// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_param
//  Description : Parametrised up/down loadable counter with modulus MAX_VAL+1,
//                wrap or saturate at the bounds, combinational terminal
//                count for cascading and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] c_max = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_rst = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next_q;
    logic             w_wrap;
    logic [WIDTH-1:0] w_load_val;

    updown_counter_param_next_val #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next_val (
        .q      (r_q),
        .en     (en),
        .mode   (mode),
        .sat    (sat),
        .next_q (w_next_q),
        .tc     (tc),
        .wrap   (w_wrap)
    );

    // Out-of-range load values clamp to the top of the count range. When
    // MAX_VAL is the full binary range the compare is simply never true.
    assign w_load_val = (data_in > c_max) ? c_max : data_in;

    // Count register and sticky overflow: reset > load > enable, else hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= c_rst;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_q   <= w_load_val;
            r_ovf <= 1'b0;
        end else if (en) begin
            r_q <= w_next_q;
            if (w_wrap) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign q   = r_q;
    assign ovf = r_ovf;

endmodule : updown_counter_param
`default_nettype wire
